// File: rtl/pipe_mux_stage.sv
// N-to-1 select into a registered elastic stage with a 2-entry skid (out reg + skid reg).
// Latency 1 cycle when empty; in_ready comes from state flops only, so out_ready never reaches it combinationally.
module pipe_mux_stage #(
    parameter int WIDTH = 32,
    parameter int N_IN  = 5,
    parameter int CNT_W = 8
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [N_IN*WIDTH-1:0]   in_data,
    input  logic [((($clog2(N_IN)) < 1) ? 1 : $clog2(N_IN))-1:0] sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    flush,
    input  logic                    err_clr,
    output logic                    sel_err,
    output logic [CNT_W-1:0]        err_count
);

    localparam int SEL_W = ($clog2(N_IN) < 1) ? 1 : $clog2(N_IN);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [WIDTH-1:0]   skid_q, skid_d;
    logic               sel_err_q, sel_err_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic [WIDTH-1:0]   word;
    logic               sel_oob;
    logic               accept;
    logic               drain;
    logic               err_hit;

    // Unmatched select indices fall back to input 0 and are flagged out-of-range.
    always_comb begin
        word    = in_data[WIDTH-1:0];
        sel_oob = 1'b1;
        for (int k = 0; k < N_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                word    = in_data[k*WIDTH +: WIDTH];
                sel_oob = 1'b0;
            end
        end
    end

    assign in_ready  = (state_q != S_FULL);
    assign out_valid = (state_q != S_EMPTY);
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;
    assign out_data  = out_q;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = S_EMPTY;
            out_d   = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        state_d = S_ONE;
                        out_d   = word;
                    end
                end
                S_ONE: begin
                    if (accept && drain) begin
                        out_d = word;
                    end else if (accept) begin
                        state_d = S_FULL;
                        skid_d  = word;
                    end else if (drain) begin
                        state_d = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (drain) begin
                        state_d = S_ONE;
                        out_d   = skid_q;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                end
            endcase
        end
    end

    // A word dropped by flush is not an accepted word, so it never counts.
    assign err_hit = accept & sel_oob & ~flush;

    always_comb begin
        sel_err_d = sel_err_q;
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            sel_err_d = err_hit;
            err_cnt_d = CNT_W'(err_hit);
        end else if (err_hit) begin
            sel_err_d = 1'b1;
            if (err_cnt_q != {CNT_W{1'b1}}) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end
    end

    assign sel_err   = sel_err_q;
    assign err_count = err_cnt_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_EMPTY;
            out_q     <= '0;
            skid_q    <= '0;
            sel_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            skid_q    <= skid_d;
            sel_err_q <= sel_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_mux_stage.sv
// Bench for pipe_mux_stage: three instances (default, 2-bit error counter, 8-bit/2-input)
// driven by shared stimulus and checked every cycle against a queue-style reference model.
module tb_pipe_mux_stage;

    logic        CLK;
    logic        RST_N;
    logic [2:0]  sel;
    logic        in_valid;
    logic        out_ready;
    logic        flush;
    logic        err_clr;
    logic [31:0] w [5];

    logic [159:0] in_data0;
    logic [15:0]  in_data2;
    logic         sel2;

    assign in_data0 = {w[4], w[3], w[2], w[1], w[0]};
    assign in_data2 = {w[1][7:0], w[0][7:0]};
    assign sel2     = sel[0];

    logic        ir [3];
    logic        ov [3];
    logic        se [3];
    logic [31:0] od [3];
    logic [7:0]  ec [3];

    logic [31:0] od0, od1;
    logic [7:0]  od2;
    logic [7:0]  ec0, ec2;
    logic [1:0]  ec1;

    pipe_mux_stage #(.WIDTH(32), .N_IN(5), .CNT_W(8)) u_main (
        .CLK(CLK), .RST_N(RST_N), .in_data(in_data0), .sel(sel), .in_valid(in_valid),
        .in_ready(ir[0]), .out_data(od0), .out_valid(ov[0]), .out_ready(out_ready),
        .flush(flush), .err_clr(err_clr), .sel_err(se[0]), .err_count(ec0));

    pipe_mux_stage #(.WIDTH(32), .N_IN(5), .CNT_W(2)) u_sat (
        .CLK(CLK), .RST_N(RST_N), .in_data(in_data0), .sel(sel), .in_valid(in_valid),
        .in_ready(ir[1]), .out_data(od1), .out_valid(ov[1]), .out_ready(out_ready),
        .flush(flush), .err_clr(err_clr), .sel_err(se[1]), .err_count(ec1));

    pipe_mux_stage #(.WIDTH(8), .N_IN(2), .CNT_W(8)) u_small (
        .CLK(CLK), .RST_N(RST_N), .in_data(in_data2), .sel(sel2), .in_valid(in_valid),
        .in_ready(ir[2]), .out_data(od2), .out_valid(ov[2]), .out_ready(out_ready),
        .flush(flush), .err_clr(err_clr), .sel_err(se[2]), .err_count(ec2));

    assign od[0] = od0;
    assign od[1] = od1;
    assign od[2] = {24'b0, od2};
    assign ec[0] = ec0;
    assign ec[1] = {6'b0, ec1};
    assign ec[2] = ec2;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: a bounded FIFO of up to two words per instance.
    int          n_in_p [3] = '{5, 5, 2};
    int          cmax   [3] = '{255, 3, 255};
    logic [31:0] mask   [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00FF};
    logic [31:0] m_buf  [3][2];
    int          m_n    [3];
    logic [31:0] m_out  [3];
    logic        m_err  [3];
    int          m_cnt  [3];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_n[i] = 0; m_out[i] = 0; m_err[i] = 1'b0; m_cnt[i] = 0;
            m_buf[i][0] = 0; m_buf[i][1] = 0;
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 3; i++) begin
            int s;
            logic [31:0] wd;
            bit acc, drn, hit;
            s   = (i == 2) ? int'(sel[0]) : int'(sel);
            wd  = ((s < n_in_p[i]) ? w[s] : w[0]) & mask[i];
            acc = in_valid && (m_n[i] < 2);
            drn = (m_n[i] > 0) && out_ready;
            hit = !flush && acc && (s >= n_in_p[i]);
            if (flush) begin
                m_n[i] = 0;
                m_out[i] = 0;
            end else begin
                if (drn) begin
                    m_buf[i][0] = m_buf[i][1];
                    m_n[i]--;
                end
                if (acc) begin
                    m_buf[i][m_n[i]] = wd;
                    m_n[i]++;
                end
                if (m_n[i] > 0) m_out[i] = m_buf[i][0];
            end
            if (err_clr) begin
                m_err[i] = hit;
                m_cnt[i] = hit ? 1 : 0;
            end else if (hit) begin
                m_err[i] = 1'b1;
                if (m_cnt[i] < cmax[i]) m_cnt[i]++;
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d.out_valid", i), 32'(ov[i]), 32'(m_n[i] > 0));
            chk($sformatf("u%0d.in_ready", i), 32'(ir[i]), 32'(m_n[i] < 2));
            chk($sformatf("u%0d.out_data", i), od[i], m_out[i]);
            chk($sformatf("u%0d.sel_err", i), 32'(se[i]), 32'(m_err[i]));
            chk($sformatf("u%0d.err_count", i), 32'(ec[i]), 32'(m_cnt[i]));
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        if (RST_N) model_update();
        @(negedge CLK);
        compare_all();
    endtask

    task automatic drive(input bit v, input logic [2:0] s, input bit r, input bit f, input bit c);
        in_valid = v; sel = s; out_ready = r; flush = f; err_clr = c;
    endtask

    initial begin
        RST_N = 1'b0;
        drive(0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) w[k] = 32'hA0 + k;
        model_reset();
        @(negedge CLK);
        compare_all();
        chk("reset.out_valid", 32'(ov[0]), 32'd0);
        chk("reset.in_ready", 32'(ir[0]), 32'd1);
        chk("reset.err_count", 32'(ec[0]), 32'd0);
        RST_N = 1'b1;

        // Streaming, one word per cycle, no bubbles.
        for (int k = 0; k < 5; k++) begin
            drive(1, 3'(k), 1, 0, 0);
            cyc();
            chk("stream.out_data", od[0], 32'hA0 + k);
            chk("stream.out_valid", 32'(ov[0]), 32'd1);
        end
        drive(0, 0, 1, 0, 0);
        cyc();
        chk("stream.drained", 32'(ov[0]), 32'd0);

        // Back-pressure into the skid.
        drive(1, 1, 0, 0, 0); cyc();
        chk("bp.ready_after1", 32'(ir[0]), 32'd1);
        drive(1, 2, 0, 0, 0); cyc();
        chk("bp.ready_after2", 32'(ir[0]), 32'd0);
        chk("bp.hold_a1", od[0], 32'hA1);
        drive(1, 3, 0, 0, 0); cyc();
        chk("bp.stable_a1", od[0], 32'hA1);
        drive(1, 3, 1, 0, 0); cyc();
        chk("bp.skid_a2", od[0], 32'hA2);
        chk("bp.ready_again", 32'(ir[0]), 32'd1);
        cyc();
        chk("bp.a3", od[0], 32'hA3);
        drive(0, 0, 1, 0, 0); cyc();

        // Flush while full with a word offered.
        drive(1, 2, 0, 0, 0); cyc(); cyc();
        chk("flush.full", 32'(ir[0]), 32'd0);
        drive(1, 4, 0, 1, 0); cyc();
        chk("flush.out_valid", 32'(ov[0]), 32'd0);
        chk("flush.in_ready", 32'(ir[0]), 32'd1);
        chk("flush.out_data", od[0], 32'd0);
        drive(0, 0, 1, 0, 0); cyc();
        chk("flush.nothing", 32'(ov[0]), 32'd0);

        // Out-of-range select and counter saturation.
        for (int k = 0; k < 4; k++) begin
            drive(1, 7, 1, 0, 0); cyc();
            chk("err.default_leg", od[1], 32'hA0);
        end
        chk("err.sticky", 32'(se[1]), 32'd1);
        chk("err.saturated", 32'(ec[1]), 32'd3);
        chk("err.main_count", 32'(ec[0]), 32'd4);
        drive(0, 7, 1, 0, 1); cyc();
        chk("err.clr_flag", 32'(se[1]), 32'd0);
        chk("err.clr_count", 32'(ec[1]), 32'd0);
        drive(0, 7, 1, 0, 0); cyc();
        chk("err.no_accept", 32'(ec[1]), 32'd0);
        drive(1, 7, 1, 0, 1); cyc();
        chk("err.clr_and_hit", 32'(ec[1]), 32'd1);
        drive(1, 7, 1, 1, 1); cyc();
        chk("err.flush_no_count", 32'(ec[0]), 32'd0);

        // Two-input, 8-bit instance.
        drive(1, 1, 1, 0, 0); cyc();
        chk("small.sel1", od[2], 32'hA1);
        chk("small.no_err", 32'(se[2]), 32'd0);
        drive(1, 0, 1, 0, 0); cyc();
        chk("small.sel0", od[2], 32'hA0);

        // Asynchronous reset while full.
        drive(1, 1, 0, 0, 0); cyc(); cyc(); cyc();
        chk("rst.pre_full", 32'(ir[0]), 32'd0);
        #2 RST_N = 1'b0;
        #1;
        model_reset();
        chk("rst.out_valid", 32'(ov[0]), 32'd0);
        chk("rst.out_data", od[0], 32'd0);
        chk("rst.in_ready", 32'(ir[0]), 32'd1);
        chk("rst.err_count", 32'(ec[0]), 32'd0);
        cyc();
        RST_N = 1'b1;

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            for (int k = 0; k < 5; k++) w[k] = $urandom;
            drive(($urandom % 4) != 0, 3'($urandom % 8), ($urandom % 3) != 0,
                  ($urandom % 40) == 0, ($urandom % 50) == 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
